// File: rtl/branch_pht_predictor_if.sv
// Pipeline-side bundle of the branch predictor: ID lookup, EX resolve and perf readout.
interface branch_pht_predictor_if #(
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned PERF_W = 32
);
    logic              id_branch;
    logic [31:0]       id_pc;
    logic [IDX_W-1:0]  id_idx;
    logic              pred;
    logic              ex_branch;
    logic              ex_taken;
    logic              ex_pred;
    logic [IDX_W-1:0]  ex_idx;
    logic              fail;
    logic              flush;
    logic [PERF_W-1:0] perf_branches;
    logic [PERF_W-1:0] perf_misses;

    modport master (
        output id_branch, id_pc, ex_branch, ex_taken, ex_pred, ex_idx,
        input  id_idx, pred, fail, flush, perf_branches, perf_misses
    );

    modport slave (
        input  id_branch, id_pc, ex_branch, ex_taken, ex_pred, ex_idx,
        output id_idx, pred, fail, flush, perf_branches, perf_misses
    );
endinterface

// File: rtl/branch_pht_predictor.sv
// Gshare/bimodal PHT branch predictor: predicts in ID, trains in EX, flags flush and
// keeps resolved-branch / misprediction counters.
module branch_pht_predictor #(
    parameter int unsigned CNT_W      = 2,
    parameter int unsigned IDX_W      = 4,
    parameter int unsigned GHR_W      = 4,
    parameter int unsigned INIT_TAKEN = 1,
    parameter int unsigned PERF_W     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    branch_pht_predictor_if.slave  bus
);
    localparam int unsigned ENTRIES = 1 << IDX_W;
    localparam int unsigned GHR_N   = (GHR_W > 0) ? GHR_W : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_INIT = (INIT_TAKEN != 0) ? CNT_MAX : '0;

    logic [CNT_W-1:0]  pht [ENTRIES];
    logic [GHR_N-1:0]  ghr;
    logic [PERF_W-1:0] branches;
    logic [PERF_W-1:0] misses;

    logic [IDX_W-1:0]  hash;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  upd_cur;
    logic [CNT_W-1:0]  upd_next;
    logic              raw;
    logic              fail;
    logic              pred;

    // GHR folds into the low index bits; bimodal mode keeps the raw PC index.
    generate
        if (GHR_W > 0) begin : g_gshare
            assign hash = IDX_W'(ghr);
        end else begin : g_bimodal
            logic unused_ghr;
            assign hash       = '0;
            assign unused_ghr = ^ghr;
        end
    endgenerate

    logic unused_pc;
    assign unused_pc = ^{bus.id_pc[31:IDX_W+2], bus.id_pc[1:0]};

    assign idx  = bus.id_pc[IDX_W+1:2] ^ hash;
    assign cnt  = pht[idx];
    assign raw  = cnt[CNT_W-1];
    assign fail = bus.ex_branch & (bus.ex_taken ^ bus.ex_pred);

    // A mispredict flushes the ID instruction anyway, so steer it with the resolved outcome.
    always_comb begin
        pred = 1'b0;
        if (bus.id_branch) begin
            pred = fail ? bus.ex_taken : raw;
        end
    end

    always_comb begin
        upd_cur  = pht[bus.ex_idx];
        upd_next = upd_cur;
        if (bus.ex_taken) begin
            if (upd_cur != CNT_MAX) upd_next = upd_cur + CNT_W'(1);
        end else begin
            if (upd_cur != '0) upd_next = upd_cur - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                pht[i] <= CNT_INIT;
            end
            ghr      <= '0;
            branches <= '0;
            misses   <= '0;
        end else if (bus.ex_branch) begin
            pht[bus.ex_idx] <= upd_next;
            ghr             <= GHR_N'({ghr, bus.ex_taken});
            branches        <= branches + PERF_W'(1);
            if (fail) misses <= misses + PERF_W'(1);
        end
    end

    assign bus.id_idx        = idx;
    assign bus.pred          = pred;
    assign bus.fail          = fail;
    assign bus.flush         = fail | pred;
    assign bus.perf_branches = branches;
    assign bus.perf_misses   = misses;
endmodule

// File: doc/branch_pht_predictor.md
Name: branch_pht_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage pipeline.
- Holds a pattern history table (PHT) of N-bit saturating counters, indexed by PC bits. The index is optionally XOR-hashed with a global history register (GHR) in gshare style.
- Predicts in ID, resolves in EX, and raises flush on a taken prediction or a misprediction.
- Adds per-branch-index tracking and performance counters.

Parameters:
- CNT_W, 2: counter width in bits, 1..4. Prediction is the counter MSB.
- IDX_W, 4: PHT index width. The table has 2^IDX_W entries.
- GHR_W, 4: global history length, 0..IDX_W. 0 selects pure bimodal indexing.
- INIT_TAKEN, 1: reset value of counters. 1 = all ones (strongly taken); 0 = all zeros.
- PERF_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-low
- id_branch  in  1  ID-stage instruction is a conditional branch
- id_pc  in  32  PC of the ID-stage instruction
- id_idx  out  IDX_W  PHT index used for this ID prediction; pipelined to EX by the ID/EX register
- pred  out  1  ID-stage prediction: take the branch
- ex_branch  in  1  EX-stage instruction is a conditional branch
- ex_taken  in  1  resolved branch outcome (ALU zero/compare)
- ex_pred  in  1  prediction made for this branch in ID, pipelined
- ex_idx  in  IDX_W  index made for this branch in ID, pipelined
- fail  out  1  EX branch was mispredicted
- flush  out  1  flush IF/ID
- perf_branches  out  PERF_W  resolved branch count
- perf_misses  out  PERF_W  misprediction count

Behaviour:
- Reset:
  - Applied synchronously when rst=0 at a rising clk edge.
  - Every PHT counter is set to all ones if INIT_TAKEN=1, else all zeros.
  - GHR, perf_branches and perf_misses are set to 0.
  - Reset has priority over any concurrent update. An in-flight EX update in the reset cycle is discarded.
- Index:
  - id_idx = id_pc[IDX_W+1:2] XOR {zeros, GHR[GHR_W-1:0]}.
  - When GHR_W=0 there is no XOR.
  - id_idx is driven whenever id_pc is valid, regardless of id_branch.
- Lookup: combinational. cnt = PHT[id_idx]; raw = cnt[CNT_W-1].
- fail = ex_branch AND (ex_taken != ex_pred). This compares against the pipelined prediction, not the current table state.
- pred:
  - 0 when id_branch=0.
  - When id_branch=1 and fail=1, pred = ex_taken. The ID instruction is about to be flushed; this keeps behaviour equal to the previous 2-bit predictor.
  - Otherwise pred = raw.
- flush = fail OR pred.
- Update, on the clock edge when rst=1 and ex_branch=1:
  - PHT[ex_idx] increments if ex_taken=1, saturating at 2^CNT_W-1.
  - PHT[ex_idx] decrements if ex_taken=0, saturating at 0.
  - Only the addressed entry changes.
  - GHR <= {GHR[GHR_W-2:0], ex_taken}. This is a non-speculative, resolve-time update.
  - perf_branches increments.
  - perf_misses increments if fail=1.
  - Both perf counters wrap modulo 2^PERF_W.
- When ex_branch=0 the PHT, GHR and perf counters hold.
- Same-cycle read/write to one entry (id_idx == ex_idx with ex_branch=1): ID reads the pre-update value. There is no bypass.
- Same-cycle GHR: id_idx uses the pre-update GHR.
- Outputs are combinational from state and inputs. Table state has zero added latency beyond the single update edge.
- CNT_W=1 degenerates to a 1-bit last-outcome predictor. Saturation still applies.

Test Plan:
- Reset check: with defaults, hold rst=0 for 2 cycles, then release. Sweep id_pc over all 16 indices with id_branch=1 -> pred=1 and flush=1 everywhere; perf counters read 0.
- Saturation: CNT_W=2, GHR_W=0, entry 3 (id_pc=0x0C).
  - Four ex_branch=1 pulses with ex_taken=0 and ex_idx=3 -> pred for pc 0x0C stays 1 after the 1st pulse and reads 0 after the 2nd, 3rd and 4th.
  - Then a single taken pulse -> counter = 01, pred still 0.
- Mispredict: ex_branch=1, ex_pred=1, ex_taken=0, with id_branch=1 in the same cycle -> fail=1, pred=0, flush=1. perf_misses goes 0->1 and perf_branches goes 0->1 on the next edge.
- gshare: GHR_W=4.
  - Resolve taken, not, taken, taken -> GHR = 4'b1011.
  - Next id_pc=0x00000010 -> id_idx = 4'b0100 XOR 4'b1011 = 4'b1111.
- Collision: ex_idx == id_idx, ex_branch=1, ex_taken=0, counter=10 -> pred=1 in that cycle and pred=0 in the following cycle.
- Mid-operation reset: drive rst=0 during an ex_branch=1 cycle after 5 resolved branches -> on that edge all counters return to 11, GHR=0 and perf_branches=0. The update is not applied.
